ws2812_led_sequencer: RTL

- Upstream feeder for the ws2812 core. Holds a double-buffered per-LED GRB frame that the host writes.
- Walks the frame one LED per slot, presenting a one-hot led_mask, the matching rgb_colour and a write strobe to the core.
- Replaces ad-hoc wheel/mask logic in top-level designs. The host loads a frame, then requests a swap that takes effect only at a frame boundary.

---
 rtl/ws2812_pkg.sv | 26 ++
 rtl/ws2812_led_sequencer_if.sv | 20 ++
 rtl/ws2812_frame_buf.sv | 51 +++++
 rtl/ws2812_led_sequencer.sv | 132 +++++++++++++
 4 files changed

// File: rtl/ws2812_pkg.sv
// Shared definitions for the ws2812 LED sequencer: colour layout and the
// slot-sequencing state encoding.
package ws2812_pkg;

  // Colour word is {green, red, blue}, 8 bits each.
  localparam int RGB_W = 24;
  localparam int G_LSB = 16;
  localparam int R_LSB = 8;
  localparam int B_LSB = 0;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    STROBE = 3'd2,
    WAIT   = 3'd3,
    NEXT   = 3'd4
  } seq_state_t;

  // Build a colour word from its three channels.
  function automatic logic [RGB_W-1:0] pack_grb(input logic [7:0] g,
                                                input logic [7:0] r,
                                                input logic [7:0] b);
    return {g, r, b};
  endfunction

endpackage

// File: rtl/ws2812_led_sequencer_if.sv
// Host-side frame loading bus: back-buffer writes and the swap request.
interface ws2812_led_sequencer_if #(
  parameter int ADDR_W = 2
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [23:0]       wr_rgb;
  logic              swap_req;
  logic              swap_pending;

  modport master (
    output wr_en, wr_addr, wr_rgb, swap_req,
    input  swap_pending
  );

  modport slave (
    input  wr_en, wr_addr, wr_rgb, swap_req,
    output swap_pending
  );
endinterface

// File: rtl/ws2812_frame_buf.sv
// Double-banked per-LED colour store. The host writes the back bank, the
// sequencer reads the front bank, and flip exchanges the two roles.
module ws2812_frame_buf
  import ws2812_pkg::*;
#(
  parameter int NUM_LEDS = 4,
  parameter int ADDR_W   = $clog2(NUM_LEDS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wr_en,
  input  logic [ADDR_W-1:0]           wr_addr,
  input  logic [RGB_W-1:0]            wr_rgb,
  input  logic                        flip,
  input  logic [$clog2(NUM_LEDS)-1:0] rd_idx,
  output logic [RGB_W-1:0]            rd_rgb
);

  localparam int IDX_W = $clog2(NUM_LEDS);

  logic [RGB_W-1:0] mem [2][NUM_LEDS];
  logic             front_sel;
  logic             wr_ok_s;
  logic [IDX_W-1:0] wr_slot_s;

  // Out-of-range addresses are dropped rather than aliased onto a real LED.
  assign wr_ok_s   = wr_en && (32'(wr_addr) < 32'(NUM_LEDS));
  assign wr_slot_s = wr_addr[IDX_W-1:0];
  assign rd_rgb    = mem[front_sel][rd_idx];

  // Bank storage and front-bank select; a write coinciding with flip lands in
  // the bank that is about to become the front.
  always_ff @(posedge clk) begin
    if (!reset) begin
      front_sel <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < NUM_LEDS; i++) begin
          mem[b][i] <= '0;
        end
      end
    end else begin
      if (flip) begin
        front_sel <= ~front_sel;
      end
      if (wr_ok_s) begin
        mem[~front_sel][wr_slot_s] <= wr_rgb;
      end
    end
  end

endmodule

// File: rtl/ws2812_led_sequencer.sv
// Walks the front frame buffer one LED per slot, presenting a one-hot mask,
// its colour and a write strobe to the ws2812 core. Frame swaps requested by
// the host are deferred to the end of the frame being shown.
module ws2812_led_sequencer
  import ws2812_pkg::*;
#(
  parameter int NUM_LEDS    = 4,
  parameter int SLOT_CYCLES = 32768,
  parameter int HOLD_CYCLES = 2,
  parameter int ADDR_W      = $clog2(NUM_LEDS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    run,
  ws2812_led_sequencer_if.slave   host,
  output logic                    frame_done,
  output logic [NUM_LEDS-1:0]     led_mask,
  output logic [RGB_W-1:0]        rgb_colour,
  output logic                    write
);

  localparam int IDX_W = $clog2(NUM_LEDS);
  localparam int CNT_W = $clog2(SLOT_CYCLES);
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(NUM_LEDS - 1);
  localparam logic [CNT_W-1:0]    HOLD_END = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0]    SLOT_END = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [NUM_LEDS-1:0] MASK_ONE = NUM_LEDS'(1);

  seq_state_t       state;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] cnt;
  logic             swap_pending;
  logic [RGB_W-1:0] rd_rgb;
  logic             last_led_s;
  logic             flip_s;

  // The swap happens in the NEXT cycle that closes a frame; a request arriving
  // in that same cycle is honoured immediately.
  assign last_led_s        = (state == NEXT) && (idx == LAST_IDX);
  assign flip_s            = last_led_s && (swap_pending || host.swap_req);
  assign host.swap_pending = swap_pending;

  ws2812_frame_buf #(
    .NUM_LEDS (NUM_LEDS),
    .ADDR_W   (ADDR_W)
  ) u_frame_buf (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (host.wr_en),
    .wr_addr (host.wr_addr),
    .wr_rgb  (host.wr_rgb),
    .flip    (flip_s),
    .rd_idx  (idx),
    .rd_rgb  (rd_rgb)
  );

  // Swap request latch: set by the host, cleared when the swap is applied.
  always_ff @(posedge clk) begin
    if (!reset) begin
      swap_pending <= 1'b0;
    end else if (flip_s) begin
      swap_pending <= 1'b0;
    end else if (host.swap_req) begin
      swap_pending <= 1'b1;
    end else begin
      swap_pending <= swap_pending;
    end
  end

  // Slot sequencer. LOAD is cycle 0 of a slot, so the counter starts at 1 in
  // the following cycle and WAIT ends on cycle SLOT_CYCLES-1; NEXT adds one.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      idx        <= '0;
      cnt        <= '0;
      led_mask   <= '0;
      rgb_colour <= '0;
      write      <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          write <= 1'b0;
          if (run) begin
            idx   <= '0;
            state <= LOAD;
          end
        end
        LOAD: begin
          led_mask   <= MASK_ONE << idx;
          rgb_colour <= rd_rgb;
          cnt        <= CNT_W'(1);
          state      <= STROBE;
        end
        STROBE: begin
          write <= 1'b1;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == HOLD_END) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          write <= 1'b0;
          if (cnt == SLOT_END) begin
            frame_done <= (idx == LAST_IDX);
            state      <= NEXT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        NEXT: begin
          if (idx != LAST_IDX) begin
            idx   <= idx + IDX_W'(1);
            state <= LOAD;
          end else if (run) begin
            idx   <= '0;
            state <= LOAD;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          write <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
